// File: rtl/osc_timer_ctrl_if.sv
// Control/status bundle between a host and osc_timer_ctrl.
// The host drives the master side; the timer controller is the slave.
interface osc_timer_ctrl_if #(
  parameter int TICK_W = 8
);
  logic              start;
  logic              abort;
  logic [TICK_W-1:0] ticks;
  logic              busy;
  logic              done;
  logic [TICK_W-1:0] elapsed;

  modport master (output start, abort, ticks, input busy, done, elapsed);
  modport slave  (input start, abort, ticks, output busy, done, elapsed);
endinterface

// File: rtl/osc_timer_ctrl.sv
// Oscillator/timer sequencer: wakes the oscillator, lets it settle, counts
// synchronized TIMEROUT rising edges up to a target, then pulses DONE.
module osc_timer_ctrl #(
  parameter int TICK_W = 8,
  parameter int SETTLE = 4
) (
  input  logic            i_clk,
  input  logic            i_r,
  input  logic            i_timerout,
  output logic            o_dynoscdis,
  output logic            o_timerres,
  osc_timer_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAKE  = 2'd1,
    ST_COUNT = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [TICK_W-1:0] ONE         = {{(TICK_W-1){1'b0}}, 1'b1};
  localparam logic [TICK_W-1:0] ZERO        = {TICK_W{1'b0}};

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_sync1;
  logic              r_sync2;
  logic              r_hist;
  logic              w_tick;
  logic [TICK_W-1:0] r_target;
  logic [TICK_W-1:0] w_target_nxt;
  logic [TICK_W-1:0] r_elapsed;
  logic [TICK_W-1:0] w_elapsed_nxt;
  logic [TICK_W-1:0] w_elapsed_inc;
  logic [3:0]        r_settle;
  logic [3:0]        w_settle_nxt;
  logic              r_dynoscdis;
  logic              r_timerres;
  logic              r_busy;
  logic              r_done;

  assign w_tick        = r_sync2 & ~r_hist;
  assign w_elapsed_inc = r_elapsed + ONE;

  // TIMEROUT is asynchronous: two-flop synchronizer plus history flop for edge detect
  always_ff @(posedge i_clk) begin
    if (i_r) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= i_timerout;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  // Next-state and datapath decode
  always_comb begin
    w_state_nxt   = r_state;
    w_target_nxt  = r_target;
    w_elapsed_nxt = r_elapsed;
    w_settle_nxt  = r_settle;
    case (r_state)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          w_elapsed_nxt = ZERO;
          if (bus.ticks != ZERO) begin
            w_target_nxt = bus.ticks;
            w_settle_nxt = 4'd0;
            w_state_nxt  = ST_WAKE;
          end else begin
            w_state_nxt = ST_FIN;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAKE: begin
        if (bus.abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_settle_nxt = r_settle + 4'd1;
          if (r_settle == SETTLE_LAST) begin
            w_state_nxt = ST_COUNT;
          end else begin
            w_state_nxt = ST_WAKE;
          end
        end
      end
      ST_COUNT: begin
        // Abort beats a coincident tick, so the count is frozen
        if (bus.abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tick) begin
          w_elapsed_nxt = w_elapsed_inc;
          if (w_elapsed_inc == r_target) begin
            w_state_nxt = ST_FIN;
          end else begin
            w_state_nxt = ST_COUNT;
          end
        end else begin
          w_state_nxt = ST_COUNT;
        end
      end
      ST_FIN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs decoded from the next state
  always_ff @(posedge i_clk) begin
    if (i_r) begin
      r_state     <= ST_IDLE;
      r_target    <= ZERO;
      r_elapsed   <= ZERO;
      r_settle    <= 4'd0;
      r_dynoscdis <= 1'b1;
      r_timerres  <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_target    <= w_target_nxt;
      r_elapsed   <= w_elapsed_nxt;
      r_settle    <= w_settle_nxt;
      r_dynoscdis <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_FIN);
      r_timerres  <= (w_state_nxt != ST_COUNT);
      r_busy      <= (w_state_nxt == ST_WAKE) || (w_state_nxt == ST_COUNT);
      r_done      <= (w_state_nxt == ST_FIN);
    end
  end

  assign o_dynoscdis = r_dynoscdis;
  assign o_timerres  = r_timerres;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.elapsed = r_elapsed;
endmodule

// File: tb/tb_osc_timer_ctrl.sv
// Bench for osc_timer_ctrl: directed scenarios plus random traffic, all
// checked every cycle against an interval-level reference model.
module tb_osc_timer_ctrl;
  localparam int TICK_W = 8;
  localparam int SETTLE = 4;

  logic clk = 1'b0;
  logic r = 1'b1;
  logic timerout = 1'b0;
  logic dis;
  logic res;

  osc_timer_ctrl_if #(.TICK_W(TICK_W)) bus ();

  osc_timer_ctrl #(.TICK_W(TICK_W), .SETTLE(SETTLE)) dut (
    .i_clk       (clk),
    .i_r         (r),
    .i_timerout  (timerout),
    .o_dynoscdis (dis),
    .o_timerres  (res),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  int tgl_per = 0;
  int tgl_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // TIMEROUT source: toggles every tgl_per cycles (0 = frozen)
  always @(negedge clk) begin
    if (tgl_per > 0) begin
      if (tgl_cnt >= tgl_per - 1) begin
        timerout = ~timerout;
        tgl_cnt  = 0;
      end else begin
        tgl_cnt++;
      end
    end
  end

  // Reference model: phase 0 idle, 1 waking, 2 counting, 3 finished.
  // smp[k] is the TIMEROUT value seen k+1 edges ago; a tick is a rise
  // that has aged through the two synchronizer stages.
  int m_phase = 0;
  int m_left = 0;
  int m_elapsed = 0;
  int m_target = 0;
  bit m_smp [3] = '{1'b0, 1'b0, 1'b0};

  function automatic bit m_tick_next();
    return m_smp[0] & ~m_smp[1];
  endfunction

  always @(posedge clk) begin : mdl
    bit tk;
    tk = m_smp[1] & ~m_smp[2];
    if (r) begin
      m_phase = 0; m_left = 0; m_elapsed = 0; m_target = 0;
      m_smp = '{1'b0, 1'b0, 1'b0};
    end else begin
      case (m_phase)
        0: if (bus.start && !bus.abort) begin
             m_elapsed = 0;
             if (bus.ticks == 0) m_phase = 3;
             else begin m_target = int'(bus.ticks); m_left = SETTLE; m_phase = 1; end
           end
        1: if (bus.abort) m_phase = 0;
           else begin m_left--; if (m_left == 0) m_phase = 2; end
        2: if (bus.abort) m_phase = 0;
           else if (tk) begin
             m_elapsed = (m_elapsed + 1) % (1 << TICK_W);
             if (m_elapsed == m_target) m_phase = 3;
           end
        default: m_phase = 0;
      endcase
      m_smp[2] = m_smp[1];
      m_smp[1] = m_smp[0];
      m_smp[0] = timerout;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_dynoscdis", 32'(dis), 32'(m_phase == 0 || m_phase == 3));
      chk("m_timerres", 32'(res), 32'(m_phase != 2));
      chk("m_busy", 32'(bus.busy), 32'(m_phase == 1 || m_phase == 2));
      chk("m_done", 32'(bus.done), 32'(m_phase == 3));
      chk("m_elapsed", 32'(bus.elapsed), 32'(m_elapsed));
    end
  end

  task automatic go(input int t);
    @(negedge clk);
    bus.ticks = TICK_W'(t);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // kind 0: DONE seen, 1: ELAPSED==val, 2: TIMERRES low
  task automatic wait_for(input int kind, input int val, input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((kind == 0 && bus.done === 1'b1) ||
          (kind == 1 && bus.elapsed === TICK_W'(val)) ||
          (kind == 2 && res === 1'b0)) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  initial begin
    int saved;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.ticks = '0;
    repeat (2) @(negedge clk);
    chk("rst_dis", 32'(dis), 32'd1);
    chk("rst_res", 32'(res), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_elapsed", 32'(bus.elapsed), 32'd0);
    chk_en = 1'b1;
    r = 1'b0;

    // Basic interval of 3 ticks
    tgl_per = 10;
    go(3);
    chk("b_dis_fall", 32'(dis), 32'd0);
    chk("b_res_wake", 32'(res), 32'd1);
    repeat (SETTLE - 1) @(negedge clk);
    chk("b_res_still", 32'(res), 32'd1);
    @(negedge clk);
    chk("b_res_fall", 32'(res), 32'd0);
    wait_for(0, 0, 300, "b_done_timeout");
    chk("b_elapsed", 32'(bus.elapsed), 32'd3);
    @(negedge clk);
    chk("b_busy_after", 32'(bus.busy), 32'd0);
    chk("b_done_once", 32'(bus.done), 32'd0);

    // Zero target
    tgl_per = 0;
    go(0);
    chk("z_done", 32'(bus.done), 32'd1);
    chk("z_dis", 32'(dis), 32'd1);
    chk("z_elapsed", 32'(bus.elapsed), 32'd0);
    @(negedge clk);
    chk("z_done_end", 32'(bus.done), 32'd0);

    // Abort after the 4th tick
    tgl_per = 3;
    go(10);
    wait_for(1, 4, 300, "a_wait4_timeout");
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("a_busy", 32'(bus.busy), 32'd0);
    chk("a_done", 32'(bus.done), 32'd0);
    chk("a_elapsed", 32'(bus.elapsed), 32'd4);
    chk("a_dis", 32'(dis), 32'd1);
    chk("a_res", 32'(res), 32'd1);

    // Abort coincident with a tick
    tgl_per = 4;
    go(20);
    wait_for(2, 0, 20, "at_count_timeout");
    saved = -1;
    for (int i = 0; i < 200; i++) begin
      if (m_phase == 2 && m_tick_next() && m_elapsed >= 1) begin saved = m_elapsed; break; end
      @(negedge clk);
    end
    chk("at_found", 32'(saved >= 1), 32'd1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("at_elapsed", 32'(bus.elapsed), 32'(saved));
    chk("at_busy", 32'(bus.busy), 32'd0);

    // START+ABORT in IDLE
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1; bus.ticks = 8'd5;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("sa_busy", 32'(bus.busy), 32'd0);
    chk("sa_dis", 32'(dis), 32'd1);

    // START during COUNT is ignored
    tgl_per = 3;
    go(2);
    wait_for(2, 0, 20, "sc_count_timeout");
    bus.start = 1'b1; bus.ticks = 8'd5;
    @(negedge clk);
    bus.start = 1'b0;
    wait_for(0, 0, 300, "sc_done_timeout");
    chk("sc_elapsed", 32'(bus.elapsed), 32'd2);

    // TIMEROUT toggling through WAKE
    tgl_per = 1;
    go(50);
    wait_for(2, 0, 20, "w_count_timeout");
    chk("w_elapsed0", 32'(bus.elapsed), 32'd0);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;

    // Reset mid-interval, then a clean 1-tick interval
    tgl_per = 3;
    go(5);
    wait_for(1, 2, 300, "r_wait2_timeout");
    r = 1'b1;
    @(negedge clk);
    chk("r_dis", 32'(dis), 32'd1);
    chk("r_res", 32'(res), 32'd1);
    chk("r_busy", 32'(bus.busy), 32'd0);
    chk("r_done", 32'(bus.done), 32'd0);
    chk("r_elapsed", 32'(bus.elapsed), 32'd0);
    @(negedge clk);
    r = 1'b0;
    go(1);
    wait_for(0, 0, 300, "r_done_timeout");
    chk("r_elapsed1", 32'(bus.elapsed), 32'd1);

    // Random traffic
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      if (c % 60 == 0) tgl_per = $urandom_range(1, 6);
      bus.start = ($urandom_range(0, 7) == 0);
      bus.ticks = TICK_W'($urandom_range(0, 6));
      bus.abort = ($urandom_range(0, 39) == 0);
      r         = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0; r = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
